icache_pf_queue: RTL and testbench

- 4-entry instruction-prefetch request queue on the Icache miss side.
- Accepts prefetch block addresses from the fetch stage, drops duplicates and tracks every entry through memory issue and tag-matched data return.
- Drives the req/ptr inputs of the 4-to-1 round-robin selector and consumes its one-hot grant to pick the entry sent to memory.
- Returns filled blocks to the Icache write port.

---
 rtl/icache_pf_queue.sv | 147 ++++++++++++++
 tb/tb_icache_pf_queue.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_pf_queue.sv
// Four-entry instruction-prefetch queue on the Icache miss side.
// Entries are allocated, issued to memory through an external round-robin selector, and retired on a tag-matched return.
module icache_pf_queue #(
    parameter int unsigned ADDR_W = 29,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pf_req_i,
    input  logic [ADDR_W-1:0] pf_addr_i,
    output logic              pf_ready_o,
    input  logic              flush_i,
    input  logic              mem_busy_i,
    output logic              sel_en_o,
    output logic [3:0]        sel_req_o,
    output logic [1:0]        sel_ptr_o,
    input  logic [3:0]        sel_gnt_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [TAG_W-1:0]  mem_rsp_tag_i,
    input  logic [TAG_W-1:0]  mem_data_tag_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              fill_valid_o,
    output logic [ADDR_W-1:0] fill_addr_o,
    output logic [DATA_W-1:0] fill_data_o
);

    localparam int unsigned NUM_ENT = 4;
    localparam int unsigned IDX_W   = 2;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PENDING,
        ST_WAIT,
        ST_WAIT_DISCARD
    } ent_state_e;

    ent_state_e        state_q [NUM_ENT];
    logic [ADDR_W-1:0] addr_q  [NUM_ENT];
    logic [TAG_W-1:0]  tag_q   [NUM_ENT];
    logic [IDX_W-1:0]  ptr_q;

    logic [NUM_ENT-1:0] empty_vec;
    logic [NUM_ENT-1:0] dup_vec;
    logic [NUM_ENT-1:0] ret_hit;
    logic [IDX_W-1:0]   alloc_idx;
    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W-1:0]   ret_idx;
    logic               alloc_en;
    logic               issue_en;
    logic               ret_en;

    // Per-entry decode; discarded entries never count as duplicates
    always_comb begin
        empty_vec = '0;
        dup_vec   = '0;
        ret_hit   = '0;
        sel_req_o = '0;
        for (int i = 0; i < int'(NUM_ENT); i++) begin
            empty_vec[i] = (state_q[i] == ST_EMPTY);
            sel_req_o[i] = (state_q[i] == ST_PENDING);
            dup_vec[i]   = ((state_q[i] == ST_PENDING) || (state_q[i] == ST_WAIT)) &&
                           (addr_q[i] == pf_addr_i);
            ret_hit[i]   = (mem_data_tag_i != '0) &&
                           ((state_q[i] == ST_WAIT) || (state_q[i] == ST_WAIT_DISCARD)) &&
                           (tag_q[i] == mem_data_tag_i);
        end
    end

    // Lowest-index priority encoders
    always_comb begin
        alloc_idx = '0;
        gnt_idx   = '0;
        ret_idx   = '0;
        for (int i = int'(NUM_ENT) - 1; i >= 0; i--) begin
            if (empty_vec[i]) alloc_idx = IDX_W'(i);
            if (sel_gnt_i[i]) gnt_idx   = IDX_W'(i);
            if (ret_hit[i])   ret_idx   = IDX_W'(i);
        end
    end

    assign pf_ready_o   = |empty_vec;
    assign sel_ptr_o    = ptr_q;
    assign sel_en_o     = ~mem_busy_i & ~flush_i;
    assign mem_req_o    = |sel_gnt_i;
    assign mem_addr_o   = mem_req_o ? addr_q[gnt_idx] : '0;
    assign ret_en       = |ret_hit;
    assign fill_valid_o = ret_en && (state_q[ret_idx] == ST_WAIT);
    assign fill_addr_o  = addr_q[ret_idx];
    assign fill_data_o  = mem_data_i;

    assign alloc_en = pf_req_i && pf_ready_o && !(|dup_vec) && !flush_i;
    assign issue_en = mem_req_o && (mem_rsp_tag_i != '0) && !flush_i &&
                      (state_q[gnt_idx] == ST_PENDING);

    // Entry state, address, tag and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_ENT); i++) begin
                state_q[i] <= ST_EMPTY;
                addr_q[i]  <= '0;
                tag_q[i]   <= '0;
            end
            ptr_q <= '0;
        end else begin
            if (issue_en) ptr_q <= gnt_idx + IDX_W'(1);
            for (int i = 0; i < int'(NUM_ENT); i++) begin
                if (ret_en && (ret_idx == IDX_W'(i))) begin
                    state_q[i] <= ST_EMPTY;
                end else if (flush_i) begin
                    case (state_q[i])
                        ST_PENDING: state_q[i] <= ST_EMPTY;
                        ST_WAIT:    state_q[i] <= ST_WAIT_DISCARD;
                        default:    state_q[i] <= state_q[i];
                    endcase
                end else if (issue_en && (gnt_idx == IDX_W'(i))) begin
                    state_q[i] <= ST_WAIT;
                    tag_q[i]   <= mem_rsp_tag_i;
                end else if (alloc_en && (alloc_idx == IDX_W'(i))) begin
                    state_q[i] <= ST_PENDING;
                    addr_q[i]  <= pf_addr_i;
                end
            end
        end
    end

`ifndef SYNTHESIS
    logic tag_clash;

    // An accepted tag must not alias one still in flight (a same-cycle return frees its tag)
    always_comb begin
        tag_clash = 1'b0;
        for (int i = 0; i < int'(NUM_ENT); i++) begin
            if (((state_q[i] == ST_WAIT) || (state_q[i] == ST_WAIT_DISCARD)) &&
                (tag_q[i] == mem_rsp_tag_i) && !(ret_en && (ret_idx == IDX_W'(i))))
                tag_clash = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && issue_en)
            assert (!tag_clash) else $error("icache_pf_queue: memory tag collision");
    end
`endif

endmodule

// File: tb/tb_icache_pf_queue.sv
// Bench for icache_pf_queue: directed scenarios then random traffic, checked against a
// per-entry behavioural model; the bench also plays the round-robin selector.
module tb_icache_pf_queue;

    localparam int M_EMPTY = 0;
    localparam int M_PEND  = 1;
    localparam int M_WAIT  = 2;
    localparam int M_DISC  = 3;

    logic        clk;
    logic        rst_n;
    logic        pf_req_i;
    logic [28:0] pf_addr_i;
    logic        pf_ready_o;
    logic        flush_i;
    logic        mem_busy_i;
    logic        sel_en_o;
    logic [3:0]  sel_req_o;
    logic [1:0]  sel_ptr_o;
    logic [3:0]  sel_gnt_i;
    logic        mem_req_o;
    logic [28:0] mem_addr_o;
    logic [3:0]  mem_rsp_tag_i;
    logic [3:0]  mem_data_tag_i;
    logic [63:0] mem_data_i;
    logic        fill_valid_o;
    logic [28:0] fill_addr_o;
    logic [63:0] fill_data_o;

    icache_pf_queue dut (
        .clk(clk), .rst_n(rst_n),
        .pf_req_i(pf_req_i), .pf_addr_i(pf_addr_i), .pf_ready_o(pf_ready_o),
        .flush_i(flush_i), .mem_busy_i(mem_busy_i),
        .sel_en_o(sel_en_o), .sel_req_o(sel_req_o), .sel_ptr_o(sel_ptr_o), .sel_gnt_i(sel_gnt_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_rsp_tag_i(mem_rsp_tag_i), .mem_data_tag_i(mem_data_tag_i), .mem_data_i(mem_data_i),
        .fill_valid_o(fill_valid_o), .fill_addr_o(fill_addr_o), .fill_data_o(fill_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Reference model
    int          m_st   [4];
    logic [28:0] m_addr [4];
    logic [3:0]  m_tag  [4];
    int          m_ptr;
    int          g_idx;
    int          r_idx;
    logic        e_ready, e_en, e_mem_req, e_fill;
    logic [3:0]  e_req;
    logic [28:0] e_mem_addr, e_fill_addr;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_st[i]   = M_EMPTY;
            m_addr[i] = '0;
            m_tag[i]  = '0;
        end
        m_ptr = 0;
    endtask

    function automatic logic tag_in_use(input logic [3:0] t);
        for (int i = 0; i < 4; i++)
            if ((m_st[i] == M_WAIT || m_st[i] == M_DISC) && m_tag[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    // Expected combinational view for the current inputs; also drives the selector grant
    task automatic compute_expect();
        e_ready = 1'b0;
        e_req   = '0;
        for (int i = 0; i < 4; i++) begin
            if (m_st[i] == M_EMPTY) e_ready = 1'b1;
            if (m_st[i] == M_PEND)  e_req[i] = 1'b1;
        end
        e_en  = !mem_busy_i && !flush_i;
        g_idx = -1;
        if (e_en)
            for (int k = 0; k < 4; k++)
                if (g_idx < 0 && m_st[(m_ptr + k) % 4] == M_PEND) g_idx = (m_ptr + k) % 4;
        sel_gnt_i = '0;
        if (g_idx >= 0) sel_gnt_i[g_idx] = 1'b1;
        e_mem_req  = (g_idx >= 0);
        e_mem_addr = (g_idx >= 0) ? m_addr[g_idx] : '0;
        r_idx = -1;
        if (mem_data_tag_i != 0)
            for (int i = 0; i < 4; i++)
                if (r_idx < 0 && (m_st[i] == M_WAIT || m_st[i] == M_DISC) && m_tag[i] == mem_data_tag_i)
                    r_idx = i;
        e_fill      = (r_idx >= 0) && (m_st[r_idx] == M_WAIT);
        e_fill_addr = (r_idx >= 0) ? m_addr[r_idx] : '0;
    endtask

    task automatic check_all();
        chk("pf_ready", 64'(pf_ready_o), 64'(e_ready));
        chk("sel_req", 64'(sel_req_o), 64'(e_req));
        chk("sel_ptr", 64'(sel_ptr_o), 64'(m_ptr));
        chk("sel_en", 64'(sel_en_o), 64'(e_en));
        chk("mem_req", 64'(mem_req_o), 64'(e_mem_req));
        chk("mem_addr", 64'(mem_addr_o), 64'(e_mem_addr));
        chk("fill_valid", 64'(fill_valid_o), 64'(e_fill));
        if (e_fill) begin
            chk("fill_addr", 64'(fill_addr_o), 64'(e_fill_addr));
            chk("fill_data", fill_data_o, mem_data_i);
        end
    endtask

    // Next model state from the rules: return frees, flush kills, else issue and allocate
    task automatic model_advance();
        int   old_st [4];
        int   free_idx;
        logic dup;
        old_st = m_st;
        if (r_idx >= 0) m_st[r_idx] = M_EMPTY;
        if (flush_i) begin
            for (int i = 0; i < 4; i++) begin
                if (i != r_idx && old_st[i] == M_PEND) m_st[i] = M_EMPTY;
                if (i != r_idx && old_st[i] == M_WAIT) m_st[i] = M_DISC;
            end
        end else begin
            if (g_idx >= 0 && mem_rsp_tag_i != 0) begin
                m_st[g_idx]  = M_WAIT;
                m_tag[g_idx] = mem_rsp_tag_i;
                m_ptr        = (g_idx + 1) % 4;
            end
            if (pf_req_i) begin
                dup      = 1'b0;
                free_idx = -1;
                for (int i = 3; i >= 0; i--) begin
                    if ((old_st[i] == M_PEND || old_st[i] == M_WAIT) && m_addr[i] == pf_addr_i) dup = 1'b1;
                    if (old_st[i] == M_EMPTY) free_idx = i;
                end
                if (!dup && free_idx >= 0) begin
                    m_st[free_idx]   = M_PEND;
                    m_addr[free_idx] = pf_addr_i;
                end
            end
        end
    endtask

    task automatic step(input logic req, input logic [28:0] a, input logic fl, input logic busy,
                        input logic [3:0] rsp, input logic [3:0] dt, input logic [63:0] d);
        @(negedge clk);
        pf_req_i       = req;
        pf_addr_i      = a;
        flush_i        = fl;
        mem_busy_i     = busy;
        mem_rsp_tag_i  = rsp;
        mem_data_tag_i = dt;
        mem_data_i     = d;
        compute_expect();
        #1;
        check_all();
        model_advance();
    endtask

    initial begin
        logic [3:0] rsp;
        logic [3:0] dt;
        int         k;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        pf_req_i = 1'b0; pf_addr_i = '0; flush_i = 1'b0; mem_busy_i = 1'b0;
        sel_gnt_i = '0; mem_rsp_tag_i = '0; mem_data_tag_i = '0; mem_data_i = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        step(0, 29'h0, 0, 0, 0, 0, 64'h0);
        // Fill all four entries while issuing each one the following cycle
        step(1, 29'h100, 0, 0, 0, 0, 64'h0);
        step(1, 29'h108, 0, 0, 1, 0, 64'h0);
        step(1, 29'h110, 0, 0, 2, 0, 64'h0);
        step(1, 29'h118, 0, 0, 3, 0, 64'h0);
        step(0, 29'h0,   0, 0, 4, 0, 64'h0);
        // Out-of-order returns, then reallocate into the lowest freed entry
        step(0, 29'h0, 0, 0, 0, 3, 64'h1111_2222_3333_4444);
        step(0, 29'h0, 0, 0, 0, 1, 64'h5555_6666_7777_8888);
        step(1, 29'h120, 0, 0, 0, 0, 64'h0);
        step(0, 29'h0,   0, 0, 5, 0, 64'h0);
        // Duplicate address is dropped
        step(1, 29'h200, 0, 1, 0, 0, 64'h0);
        step(1, 29'h200, 0, 1, 0, 0, 64'h0);
        step(0, 29'h0,   0, 0, 6, 0, 64'h0);
        step(0, 29'h0, 0, 0, 0, 2, 64'h0);
        step(0, 29'h0, 0, 0, 0, 4, 64'h0);
        step(0, 29'h0, 0, 0, 0, 5, 64'hdead_beef_0000_0005);
        step(0, 29'h0, 0, 0, 0, 6, 64'hdead_beef_0000_0006);
        // Memory refuses three times before accepting
        step(1, 29'h300, 0, 0, 0, 0, 64'h0);
        step(0, 29'h0, 0, 0, 0, 0, 64'h0);
        step(0, 29'h0, 0, 0, 0, 0, 64'h0);
        step(0, 29'h0, 0, 0, 0, 0, 64'h0);
        step(0, 29'h0, 0, 0, 7, 0, 64'h0);
        step(0, 29'h0, 0, 0, 0, 7, 64'h0123_4567_89ab_cdef);
        // Demand miss holds memory while the queue fills; issue order wraps 1,2,3,0
        step(1, 29'h400, 0, 1, 0, 0, 64'h0);
        step(1, 29'h408, 0, 1, 0, 0, 64'h0);
        step(1, 29'h410, 0, 1, 0, 0, 64'h0);
        step(1, 29'h418, 0, 1, 0, 0, 64'h0);
        step(0, 29'h0, 0, 0, 8,  0, 64'h0);
        step(0, 29'h0, 0, 0, 9,  0, 64'h0);
        step(0, 29'h0, 0, 0, 10, 0, 64'h0);
        step(0, 29'h0, 0, 0, 11, 0, 64'h0);
        // Flush with two in flight and one pending; late returns must not fill
        step(0, 29'h0, 0, 0, 0, 8, 64'h8);
        step(0, 29'h0, 0, 0, 0, 9, 64'h9);
        step(1, 29'h500, 0, 1, 0, 0, 64'h0);
        step(0, 29'h0, 1, 0, 0, 0, 64'h0);
        step(0, 29'h0, 0, 0, 0, 10, 64'ha);
        step(0, 29'h0, 0, 0, 0, 11, 64'hb);
        step(0, 29'h0, 0, 0, 0, 0, 64'h0);
        // Return landing in the flush cycle still fills
        step(1, 29'h600, 0, 0, 0, 0, 64'h0);
        step(0, 29'h0, 0, 0, 12, 0, 64'h0);
        step(0, 29'h0, 1, 0, 0, 12, 64'hcafe_f00d_1234_5678);
        step(0, 29'h0, 0, 0, 0, 0, 64'h0);
        // Asynchronous reset with entries pending and in flight
        step(1, 29'h700, 0, 0, 0, 0, 64'h0);
        step(1, 29'h708, 0, 0, 13, 0, 64'h0);
        @(negedge clk);
        pf_req_i = 1'b0; flush_i = 1'b0; mem_busy_i = 1'b0; sel_gnt_i = '0;
        mem_rsp_tag_i = '0; mem_data_tag_i = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_pf_ready", 64'(pf_ready_o), 64'd1);
        chk("rst_sel_req", 64'(sel_req_o), 64'd0);
        chk("rst_sel_ptr", 64'(sel_ptr_o), 64'd0);
        chk("rst_mem_req", 64'(mem_req_o), 64'd0);
        chk("rst_fill_valid", 64'(fill_valid_o), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 29'h0, 0, 0, 0, 13, 64'hffff_0000_ffff_0000);
        step(0, 29'h0, 0, 0, 0, 0, 64'h0);

        // Random traffic on a small address pool to provoke duplicates
        for (int n = 0; n < 600; n++) begin
            rsp = '0;
            if ($urandom_range(0, 3) != 0) begin
                do rsp = 4'($urandom_range(1, 15)); while (tag_in_use(rsp));
            end
            dt = '0;
            case ($urandom_range(0, 3))
                0, 1: begin
                    k = int'($urandom_range(0, 3));
                    if (m_st[k] == M_WAIT || m_st[k] == M_DISC) dt = m_tag[k];
                end
                2: dt = 4'($urandom_range(1, 15));
                default: dt = '0;
            endcase
            step(1'($urandom_range(0, 1)), 29'(32'h40 + $urandom_range(0, 7)),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 4) == 0),
                 rsp, dt, {$urandom, $urandom});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
